// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared state, opcode, funct, ALU and select encodings for mc_ctrl
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11,
    S_TRAP   = 4'd12
  } state_t;

  // instruction bits [31:26]
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // instruction bits [5:0] for R-type
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_NOR = 6'b100111;

  // must match the ALU's own operation encodings
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  // ALU operand B select
  localparam logic [1:0] ALUB_REGB    = 2'b00;
  localparam logic [1:0] ALUB_FOUR    = 2'b01;
  localparam logic [1:0] ALUB_IMM     = 2'b10;
  localparam logic [1:0] ALUB_IMM_SH2 = 2'b11;

  // next-PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_ctrl_if.sv
// rtl/mc_ctrl_if.sv - controller <-> datapath bundle (ALU selects, enables, memory handshake)
interface mc_ctrl_if;
  logic [5:0] opcode_i;
  logic [5:0] funct_i;
  logic       zf_i;
  logic       mem_ready_i;
  logic [3:0] alu_op_o;
  logic       alu_src_a_o;
  logic [1:0] alu_src_b_o;
  logic [1:0] pc_src_o;
  logic       pc_we_o;
  logic       ir_we_o;
  logic       iord_o;
  logic       mem_re_o;
  logic       mem_we_o;
  logic       reg_we_o;
  logic       reg_dst_o;
  logic       mem_to_reg_o;
  logic       retire_o;
  logic       illegal_o;
  logic [3:0] state_o;

  // controller side
  modport master (
    input  opcode_i, funct_i, zf_i, mem_ready_i,
    output alu_op_o, alu_src_a_o, alu_src_b_o, pc_src_o, pc_we_o, ir_we_o,
           iord_o, mem_re_o, mem_we_o, reg_we_o, reg_dst_o, mem_to_reg_o,
           retire_o, illegal_o, state_o
  );

  // datapath side
  modport slave (
    output opcode_i, funct_i, zf_i, mem_ready_i,
    input  alu_op_o, alu_src_a_o, alu_src_b_o, pc_src_o, pc_we_o, ir_we_o,
           iord_o, mem_re_o, mem_we_o, reg_we_o, reg_dst_o, mem_to_reg_o,
           retire_o, illegal_o, state_o
  );
endinterface

// File: rtl/mc_ctrl_alu_dec.sv
// rtl/mc_ctrl_alu_dec.sv - R-type funct to ALU op decoder, shared with future controllers
module alu_dec
  import mc_pkg::*;
(
  input  logic [5:0] i_funct,
  output logic [3:0] o_alu_op,
  output logic       o_valid
);

  // map funct to ALU op; unknown funct is flagged invalid and parks the op at ADD
  always_comb begin
    o_alu_op = ALU_ADD;
    o_valid  = 1'b1;
    case (i_funct)
      FN_ADD:  o_alu_op = ALU_ADD;
      FN_SUB:  o_alu_op = ALU_SUB;
      FN_AND:  o_alu_op = ALU_AND;
      FN_OR:   o_alu_op = ALU_OR;
      FN_SLT:  o_alu_op = ALU_SLT;
      FN_NOR:  o_alu_op = ALU_NOR;
      default: o_valid  = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multicycle MIPS-subset control FSM driving the DPTR datapath
module mc_ctrl
  import mc_pkg::*;
#(
  parameter logic [3:0] RESET_STATE = 4'd0,
  parameter bit         TRAP_STICKY = 1'b1
) (
  input  logic      clk_i,
  input  logic      rst_i,
  mc_ctrl_if.master bus
);

  state_t     r_state;
  logic [3:0] w_dec_op;
  logic       w_dec_valid;

  alu_dec u_alu_dec (
    .i_funct  (bus.funct_i),
    .o_alu_op (w_dec_op),
    .o_valid  (w_dec_valid)
  );

  // state sequencing; memory states hold until the memory reports ready
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= state_t'(RESET_STATE);
    end else begin
      case (r_state)
        S_FETCH:  if (bus.mem_ready_i) r_state <= S_DECODE;
        S_DECODE: begin
          case (bus.opcode_i)
            OP_RTYPE:     r_state <= S_EXEC;
            OP_LW, OP_SW: r_state <= S_MEMADR;
            OP_BEQ:       r_state <= S_BRANCH;
            OP_ADDI:      r_state <= S_ADDIEX;
            OP_J:         r_state <= S_JUMP;
            default:      r_state <= S_TRAP;
          endcase
        end
        S_MEMADR: r_state <= (bus.opcode_i == OP_LW) ? S_MEMRD : S_MEMWR;
        S_MEMRD:  if (bus.mem_ready_i) r_state <= S_MEMWB;
        S_MEMWR:  if (bus.mem_ready_i) r_state <= S_FETCH;
        S_EXEC:   r_state <= w_dec_valid ? S_ALUWB : S_TRAP;
        S_ADDIEX: r_state <= S_ADDIWB;
        S_TRAP:   r_state <= TRAP_STICKY ? S_TRAP : S_FETCH;
        // MEMWB, ALUWB, BRANCH, ADDIWB, JUMP retire; codes 13-15 recover here too
        default:  r_state <= S_FETCH;
      endcase
    end
  end

  // Moore outputs; reset masks every enable so an abandoned instruction writes nothing
  always_comb begin
    bus.alu_op_o     = ALU_ADD;
    bus.alu_src_a_o  = 1'b0;
    bus.alu_src_b_o  = ALUB_REGB;
    bus.pc_src_o     = PCSRC_ALU;
    bus.pc_we_o      = 1'b0;
    bus.ir_we_o      = 1'b0;
    bus.iord_o       = 1'b0;
    bus.mem_re_o     = 1'b0;
    bus.mem_we_o     = 1'b0;
    bus.reg_we_o     = 1'b0;
    bus.reg_dst_o    = 1'b0;
    bus.mem_to_reg_o = 1'b0;
    bus.retire_o     = 1'b0;
    bus.illegal_o    = 1'b0;
    if (!rst_i) begin
      case (r_state)
        S_FETCH: begin
          bus.mem_re_o    = 1'b1;
          bus.alu_src_b_o = ALUB_FOUR;
          bus.ir_we_o     = bus.mem_ready_i;
          bus.pc_we_o     = bus.mem_ready_i;
        end
        S_DECODE: bus.alu_src_b_o = ALUB_IMM_SH2;
        S_MEMADR, S_ADDIEX: begin
          bus.alu_src_a_o = 1'b1;
          bus.alu_src_b_o = ALUB_IMM;
        end
        S_MEMRD: begin
          bus.iord_o   = 1'b1;
          bus.mem_re_o = 1'b1;
        end
        S_MEMWB: begin
          bus.reg_we_o     = 1'b1;
          bus.mem_to_reg_o = 1'b1;
          bus.retire_o     = 1'b1;
        end
        S_MEMWR: begin
          bus.iord_o   = 1'b1;
          bus.mem_we_o = 1'b1;
          bus.retire_o = bus.mem_ready_i;
        end
        S_EXEC: begin
          bus.alu_src_a_o = 1'b1;
          bus.alu_op_o    = w_dec_op;
        end
        S_ALUWB: begin
          bus.reg_we_o  = 1'b1;
          bus.reg_dst_o = 1'b1;
          bus.retire_o  = 1'b1;
        end
        S_BRANCH: begin
          bus.alu_src_a_o = 1'b1;
          bus.alu_op_o    = ALU_SUB;
          bus.pc_src_o    = PCSRC_ALUOUT;
          bus.pc_we_o     = bus.zf_i;
          bus.retire_o    = 1'b1;
        end
        S_ADDIWB: begin
          bus.reg_we_o = 1'b1;
          bus.retire_o = 1'b1;
        end
        S_JUMP: begin
          bus.pc_src_o = PCSRC_JUMP;
          bus.pc_we_o  = 1'b1;
          bus.retire_o = 1'b1;
        end
        S_TRAP:  bus.illegal_o = 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.state_o = r_state;

endmodule

// File: tb/tb_mc_ctrl.sv
// tb/tb_mc_ctrl.sv - randomized instruction stream against an instruction-level reference model
module tb_mc_ctrl;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  int   seq[$];

  mc_ctrl_if bus();

  mc_ctrl dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // {valid, alu_op} for an R-type funct
  function automatic logic [4:0] ref_alu(logic [5:0] fn);
    case (fn)
      6'h20:   return 5'b1_0010;
      6'h22:   return 5'b1_0110;
      6'h24:   return 5'b1_0000;
      6'h25:   return 5'b1_0001;
      6'h2a:   return 5'b1_0111;
      6'h27:   return 5'b1_1100;
      default: return 5'b0_0000;
    endcase
  endfunction

  // expected visible state sequence for one instruction
  task automatic build_seq(logic [5:0] op, logic [5:0] fn);
    logic [4:0] r;
    r = ref_alu(fn);
    seq = '{0, 1};
    case (op)
      6'h00: begin seq.push_back(6); seq.push_back(r[4] ? 7 : 12); end
      6'h23: begin seq.push_back(2); seq.push_back(3); seq.push_back(4); end
      6'h2b: begin seq.push_back(2); seq.push_back(5); end
      6'h04: seq.push_back(8);
      6'h08: begin seq.push_back(9); seq.push_back(10); end
      6'h02: seq.push_back(11);
      default: seq.push_back(12);
    endcase
  endtask

  // {state, alu_op, src_a, src_b, pc_src, pc_we, ir_we, iord, mem_re, mem_we,
  //  reg_we, reg_dst, mem_to_reg, retire, illegal}
  function automatic logic [22:0] exp_vec(int st, bit rdy, bit zf, logic [3:0] rop, bit rst);
    logic [3:0] aop = 4'b0010;
    logic       sa = 0;
    logic [1:0] sb = 0, ps = 0;
    logic pw = 0, iw = 0, io = 0, mr = 0, mw = 0, rw = 0, rd = 0, mtr = 0, rt = 0, il = 0;
    if (!rst) begin
      case (st)
        0:  begin mr = 1; sb = 2'b01; iw = rdy; pw = rdy; end
        1:  sb = 2'b11;
        2:  begin sa = 1; sb = 2'b10; end
        3:  begin io = 1; mr = 1; end
        4:  begin rw = 1; mtr = 1; rt = 1; end
        5:  begin io = 1; mw = 1; rt = rdy; end
        6:  begin sa = 1; aop = rop; end
        7:  begin rw = 1; rd = 1; rt = 1; end
        8:  begin sa = 1; aop = 4'b0110; ps = 2'b01; pw = zf; rt = 1; end
        9:  begin sa = 1; sb = 2'b10; end
        10: begin rw = 1; rt = 1; end
        11: begin ps = 2'b10; pw = 1; rt = 1; end
        12: il = 1;
        default: ;
      endcase
    end
    return {4'(st), aop, sa, sb, ps, pw, iw, io, mr, mw, rw, rd, mtr, rt, il};
  endfunction

  function automatic logic [22:0] obs_vec();
    return {bus.state_o, bus.alu_op_o, bus.alu_src_a_o, bus.alu_src_b_o, bus.pc_src_o,
            bus.pc_we_o, bus.ir_we_o, bus.iord_o, bus.mem_re_o, bus.mem_we_o,
            bus.reg_we_o, bus.reg_dst_o, bus.mem_to_reg_o, bus.retire_o, bus.illegal_o};
  endfunction

  task automatic do_reset(int st);
    bus.mem_ready_i = 1'b0;
    rst_i = 1'b1;
    @(negedge clk_i);
    check("reset_outputs", obs_vec(), exp_vec(st, 0, 0, 4'd0, 1));
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    check("reset_state", bus.state_o, 0);
  endtask

  task automatic run_instr(logic [5:0] op, logic [5:0] fn, bit zf, int rst_phase);
    int         retires = 0;
    bit         aborted = 0;
    logic [4:0] r;
    logic [22:0] mask;
    r = ref_alu(fn);
    // the ALU op shown in EXEC for an unknown funct is not defined
    mask = (op == 6'h00 && !r[4]) ? 23'h787FFF : 23'h7FFFFF;
    build_seq(op, fn);
    bus.opcode_i = op;
    bus.funct_i  = fn;
    bus.zf_i     = zf;
    for (int p = 0; p < seq.size() && !aborted; p++) begin
      int st    = seq[p];
      int waits = 0;
      if (st == 12) begin
        for (int k = 0; k < 10; k++) begin
          bus.mem_ready_i = 1'($urandom_range(0, 1));
          @(negedge clk_i);
          check("trap_hold", obs_vec() & mask, exp_vec(12, 0, zf, 4'd0, 0) & mask);
          retires += int'(bus.retire_o);
          @(posedge clk_i); #1;
        end
        do_reset(12);
        aborted = 1;
      end else begin
        forever begin
          bit mem = (st == 0 || st == 3 || st == 5);
          bit rdy = mem ? ((waits >= 3) || ($urandom_range(0, 2) != 0)) : 1'($urandom_range(0, 1));
          if (p == rst_phase) begin
            if (!mem || waits >= 1) begin
              do_reset(st);
              aborted = 1;
              break;
            end
            rdy = 1'b0;
          end
          bus.mem_ready_i = rdy;
          @(negedge clk_i);
          check("cycle", obs_vec() & mask, exp_vec(st, rdy, zf, r[3:0], 0) & mask);
          retires += int'(bus.retire_o);
          @(posedge clk_i); #1;
          if (mem && !rdy) waits++;
          else break;
        end
      end
    end
    check("retire_count", retires,
          (seq[seq.size()-1] == 12 || (rst_phase >= 0 && rst_phase < seq.size())) ? 0 : 1);
  endtask

  initial begin
    logic [5:0] ops [6];
    logic [5:0] fns [6];
    logic [5:0] op, fn;
    ops = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h08, 6'h02};
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h27};
    bus.opcode_i    = 6'h00;
    bus.funct_i     = 6'h20;
    bus.zf_i        = 1'b0;
    bus.mem_ready_i = 1'b1;
    @(posedge clk_i); #1;
    @(negedge clk_i);
    check("reset_outputs", obs_vec(), exp_vec(0, 0, 0, 4'd0, 1));
    @(posedge clk_i); #1;
    rst_i = 1'b0;

    run_instr(6'h00, 6'h20, 0, -1);
    run_instr(6'h23, 6'h00, 0, -1);
    run_instr(6'h04, 6'h00, 1, -1);
    run_instr(6'h04, 6'h00, 0, -1);
    run_instr(6'h00, 6'h27, 0, -1);
    run_instr(6'h00, 6'h2a, 0, -1);
    run_instr(6'h00, 6'h22, 1, -1);
    run_instr(6'h00, 6'h24, 0, -1);
    run_instr(6'h00, 6'h25, 0, -1);
    run_instr(6'h00, 6'h3f, 0, -1);
    run_instr(6'h2b, 6'h00, 0, 3);
    run_instr(6'h2b, 6'h00, 0, -1);
    run_instr(6'h3f, 6'h00, 0, -1);
    run_instr(6'h08, 6'h00, 0, -1);
    run_instr(6'h02, 6'h00, 0, -1);

    for (int i = 0; i < 150; i++) begin
      int sel = $urandom_range(0, 7);
      op = (sel < 6) ? ops[sel] : 6'($urandom_range(0, 63));
      fn = ($urandom_range(0, 3) != 0) ? fns[$urandom_range(0, 5)] : 6'($urandom_range(0, 63));
      run_instr(op, fn, 1'($urandom_range(0, 1)),
                ($urandom_range(0, 9) == 0) ? $urandom_range(0, 4) : -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multicycle control unit for the DPTR datapath. It is the producer side of the ALU interface: it generates the 4-bit ALU operation code and operand selects, and consumes the ALU zero flag.
- It sequences MIPS-subset instructions (R-type, lw, sw, beq, addi, j) through a Moore FSM.
- It drives PC, instruction-register, memory and register-file enables, with a ready handshake on memory accesses.

Parameters:
- RESET_STATE, 4'd0 (FETCH): state entered on reset.
- TRAP_STICKY, 1: 1 = TRAP holds until reset; 0 = TRAP returns to FETCH after one cycle.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous reset, active-high.
- opcode_i  in  6  instruction bits [31:26], taken from the instruction register.
- funct_i  in  6  instruction bits [5:0].
- zf_i  in  1  ALU zero flag.
- mem_ready_i  in  1  memory completes the current read/write this cycle.
- alu_op_o  out  4  ALU op: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100.
- alu_src_a_o  out  1  0 = PC, 1 = regA.
- alu_src_b_o  out  2  00 = regB, 01 = const 4, 10 = signext imm, 11 = signext imm<<2.
- pc_src_o  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- pc_we_o  out  1  PC write.
- ir_we_o  out  1  instruction register write.
- iord_o  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_re_o  out  1  memory read request.
- mem_we_o  out  1  memory write request.
- reg_we_o  out  1  register-file write.
- reg_dst_o  out  1  destination: 0 = rt, 1 = rd.
- mem_to_reg_o  out  1  writeback data: 0 = ALUOut, 1 = MDR.
- retire_o  out  1  one-cycle pulse on an instruction's final cycle.
- illegal_o  out  1  high while in TRAP.
- state_o  out  4  current state, for debug.

Behaviour:
- Reset:
  - rst_i high at a rising edge loads FETCH. All outputs are combinational from state.
  - While rst_i is high, every enable (pc_we, ir_we, mem_re, mem_we, reg_we, retire, illegal) is forced to 0, alu_op_o = 0010, and all other selects = 0.
  - Reset mid-instruction abandons the instruction; nothing is written.
- States and Moore outputs (unlisted enables = 0, unlisted selects = 0, alu_op = ADD):
  - FETCH (0): iord=0, mem_re=1, src_a=0, src_b=01, pc_src=00. ir_we and pc_we = mem_ready_i. Stay while !mem_ready_i, else go to DECODE.
  - DECODE (1): src_a=0, src_b=11 (branch target into ALUOut). Next state by opcode: 000000 -> EXEC; 100011 or 101011 -> MEMADR; 000100 -> BRANCH; 001000 -> ADDIEX; 000010 -> JUMP; any other -> TRAP.
  - MEMADR (2): src_a=1, src_b=10. lw -> MEMRD; sw -> MEMWR.
  - MEMRD (3): iord=1, mem_re=1. Hold until mem_ready_i, then MEMWB.
  - MEMWB (4): reg_we=1, reg_dst=0, mem_to_reg=1, retire=1. Next FETCH.
  - MEMWR (5): iord=1, mem_we=1. retire = mem_ready_i. Hold until ready, then FETCH.
  - EXEC (6): src_a=1, src_b=00, alu_op from funct decode. Unknown funct -> TRAP, else ALUWB.
  - ALUWB (7): reg_we=1, reg_dst=1, mem_to_reg=0, retire=1. Next FETCH.
  - BRANCH (8): src_a=1, src_b=00, alu_op=SUB, pc_src=01, pc_we=zf_i, retire=1. Next FETCH.
  - ADDIEX (9): src_a=1, src_b=10. Next ADDIWB.
  - ADDIWB (10): reg_we=1, reg_dst=0, retire=1. Next FETCH.
  - JUMP (11): pc_src=10, pc_we=1, retire=1. Next FETCH.
  - TRAP (12): illegal=1. Behaviour set by TRAP_STICKY. Codes 13–15 are unreachable and fall to FETCH.
- Funct decode (R-type only): 100000 -> ADD, 100010 -> SUB, 100100 -> AND, 100101 -> OR, 101010 -> SLT, 100111 -> NOR.
- Latency with mem_ready_i tied high: R-type 4, lw 5, sw 4, beq 3, addi 4, j 3 cycles. Each wait cycle on memory adds one.
- mem_re/mem_we stay asserted, with the address select stable, until mem_ready_i is sampled high.
- Never more than one of mem_re/mem_we is high.
- mem_ready_i is ignored in non-memory states.

Decomposition:
- Package mc_pkg holds:
  - the state enum (4-bit codes as above);
  - opcode constants;
  - funct constants;
  - ALU op constants, identical to the ALU's encodings;
  - ALU-B and PC-source select constants.
- One sub-module, alu_dec: combinational funct -> {alu_op[3:0], valid}. It is instantiated in mc_ctrl and reusable for a future single-cycle controller.

Test Plan:
- Reset, then add (opcode 000000, funct 100000), ready=1 -> states 0,1,6,7,0. alu_op 0010 in EXEC; reg_we=1, reg_dst=1 in ALUWB; retire pulses exactly once.
- lw (100011) with ready low 2 cycles in MEMRD -> MEMRD held 3 cycles with iord=1, mem_re=1. Then MEMWB with mem_to_reg=1, reg_we=1. Total 7 cycles.
- beq (000100): zf_i=1 -> pc_we=1, pc_src=01, alu_op=0110 in BRANCH. Repeat with zf_i=0 -> pc_we=0; both retire after 3 cycles.
- nor (funct 100111) -> alu_op 1100. slt (101010) -> 0111. Illegal funct 111111 -> TRAP, illegal_o=1 held for 10 cycles (TRAP_STICKY=1).
- Assert rst_i during MEMWR with mem_we high -> same cycle mem_we_o=0. Next edge state_o=0; no retire.
- sw (101011) with ready=1 -> mem_we for 1 cycle in MEMWR, retire concurrent, reg_we never high. Opcode 111111 in DECODE -> TRAP.
